// File: rtl/select_data_param.sv
// Manual packet injector: debounced keys edit a payload and a router index, and the block drives one
// {valid, payload} word onto the selected router slot, either continuously or as a single one-shot packet.
module select_data_param #(
  parameter int ROUTERS = 100,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 14,
  parameter int DEB_CYC = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sw_on,
  input  logic                             sw_oneshot,
  input  logic                             sw_sel_data,
  input  logic                             sw_sel_router,
  input  logic                             key_inc,
  input  logic                             key_dec,
  input  logic                             key_send,
  input  logic                             net_stall,
  output logic [ROUTERS*(DATA_W+1)-1:0]    out_routers,
  output logic                             pending,
  output logic [6:0]                       hex_data_lo,
  output logic [6:0]                       hex_data_hi,
  output logic [6:0]                       hex_router_lo,
  output logic [6:0]                       hex_router_hi
);

  localparam int PW        = DATA_W + 1;
  localparam int BUS_W     = ROUTERS * PW;
  localparam int CNT_W     = $clog2(DEB_CYC + 1);
  localparam int LAST      = ROUTERS - 1;
  localparam int LAST_TENS = LAST / 10;
  localparam int LAST_ONES = LAST % 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return ~s;
  endfunction

  logic [2:0] keys_s;
  logic [2:0] pulse_s;

  assign keys_s = {key_send, key_dec, key_inc};

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_deb
      logic             s1_q;
      logic             s2_q;
      logic             acc_q;
      logic             pulse_q;
      logic [CNT_W-1:0] cnt_q;

      // A new level is accepted only after DEB_CYC consecutive samples that disagree with the old one.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          acc_q   <= 1'b0;
          pulse_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= keys_s[k];
          s2_q    <= s1_q;
          pulse_q <= 1'b0;
          if (s2_q == acc_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
            acc_q   <= s2_q;
            cnt_q   <= '0;
            pulse_q <= s2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign pulse_s[k] = pulse_q;
    end
  endgenerate

  logic              inc_s, dec_s;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] router_q, router_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;

  assign inc_s = pulse_s[0] & ~pulse_s[1];
  assign dec_s = pulse_s[1] & ~pulse_s[0];

  // Router index wraps at ROUTERS, and the BCD pair tracks it in lock-step.
  always_comb begin
    data_d   = data_q;
    router_d = router_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    if (sw_sel_data) begin
      if (inc_s) begin
        data_d = data_q + 1'b1;
      end else if (dec_s) begin
        data_d = data_q - 1'b1;
      end else begin
        data_d = data_q;
      end
    end else if (sw_sel_router) begin
      if (inc_s) begin
        if (router_q == ADDR_W'(LAST)) begin
          router_d = '0;
          tens_d   = 4'd0;
          ones_d   = 4'd0;
        end else begin
          router_d = router_q + 1'b1;
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end else if (dec_s) begin
        if (router_q == '0) begin
          router_d = ADDR_W'(LAST);
          tens_d   = 4'(LAST_TENS);
          ones_d   = 4'(LAST_ONES);
        end else begin
          router_d = router_q - 1'b1;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end else begin
        router_d = router_q;
      end
    end else begin
      data_d = data_q;
    end
  end

  logic [1:0]        state_q, state_d;
  logic              mode_q;
  logic [DATA_W-1:0] snap_data_q, snap_data_d;
  logic [ADDR_W-1:0] snap_router_q, snap_router_d;
  logic [BUS_W-1:0]  out_q, out_d;
  logic              pending_q, pending_d;

  // Leaving one-shot mode or disabling injection drops any request in flight.
  always_comb begin
    state_d       = state_q;
    snap_data_d   = snap_data_q;
    snap_router_d = snap_router_q;
    if (!sw_on || !sw_oneshot || (sw_oneshot != mode_q)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_s[2]) begin
            state_d       = ST_WAIT;
            snap_data_d   = data_q;
            snap_router_d = router_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!net_stall) begin
            state_d = ST_FIRE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_FIRE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next bus word: at most one slot is ever marked valid.
  always_comb begin
    out_d     = '0;
    pending_d = (state_d == ST_WAIT);
    if (sw_on && !sw_oneshot) begin
      out_d[int'(router_q)*PW +: PW] = {1'b1, data_q};
    end else if (state_d == ST_FIRE) begin
      out_d[int'(snap_router_q)*PW +: PW] = {1'b1, snap_data_q};
    end else begin
      out_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q        <= '0;
      router_q      <= '0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      snap_data_q   <= '0;
      snap_router_q <= '0;
      out_q         <= '0;
      pending_q     <= 1'b0;
    end else begin
      data_q        <= data_d;
      router_q      <= router_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      state_q       <= state_d;
      mode_q        <= sw_oneshot;
      snap_data_q   <= snap_data_d;
      snap_router_q <= snap_router_d;
      out_q         <= out_d;
      pending_q     <= pending_d;
    end
  end

  logic [DATA_W+7:0] data_ext_s;
  assign data_ext_s = {8'd0, data_q};

  assign out_routers   = out_q;
  assign pending       = pending_q;
  assign hex_data_lo   = seg7(data_ext_s[3:0]);
  assign hex_data_hi   = seg7(data_ext_s[7:4]);
  assign hex_router_lo = seg7(ones_q);
  assign hex_router_hi = seg7(tens_q);

endmodule

// File: tb/tb_select_data_param.sv
// Randomized self-checking bench for select_data_param against a plain-arithmetic reference model.
module tb_select_data_param;

  localparam int ROUTERS = 100;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 14;
  localparam int DEB_CYC = 16;
  localparam int PW      = DATA_W + 1;
  localparam int BUS_W   = ROUTERS * PW;
  localparam int DMOD    = 1 << DATA_W;

  logic clk = 1'b0;
  logic rst_n, sw_on, sw_oneshot, sw_sel_data, sw_sel_router;
  logic key_inc, key_dec, key_send, net_stall;
  logic [BUS_W-1:0] out_routers;
  logic pending;
  logic [6:0] hex_data_lo, hex_data_hi, hex_router_lo, hex_router_hi;

  int checks = 0;
  int errors = 0;
  int m_data = 0;
  int m_router = 0;

  always #5 clk = ~clk;

  select_data_param #(.ROUTERS(ROUTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEB_CYC(DEB_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .sw_oneshot(sw_oneshot),
    .sw_sel_data(sw_sel_data), .sw_sel_router(sw_sel_router),
    .key_inc(key_inc), .key_dec(key_dec), .key_send(key_send), .net_stall(net_stall),
    .out_routers(out_routers), .pending(pending),
    .hex_data_lo(hex_data_lo), .hex_data_hi(hex_data_hi),
    .hex_router_lo(hex_router_lo), .hex_router_hi(hex_router_hi)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return ~7'b1111110;   1: return ~7'b0110000;   2: return ~7'b1101101;   3: return ~7'b1111001;
      4: return ~7'b0110011;   5: return ~7'b1011011;   6: return ~7'b1011111;   7: return ~7'b1110000;
      8: return ~7'b1111111;   9: return ~7'b1111011;   10: return ~7'b1110111;  11: return ~7'b0011111;
      12: return ~7'b1001110;  13: return ~7'b0111101;  14: return ~7'b1001111;  15: return ~7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] exp_bus(input bit valid, input int idx, input int payload);
    logic [BUS_W-1:0] v;
    logic [DATA_W-1:0] p;
    v = '0;
    p = payload[DATA_W-1:0];
    if (valid) v[idx*PW +: PW] = {1'b1, p};
    return v;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observed bus summary: number of valid slots, last valid index, its payload.
  task automatic scan_bus(output int nvalid, output int idx, output int pay);
    nvalid = 0; idx = -1; pay = -1;
    for (int i = 0; i < ROUTERS; i++) begin
      if (out_routers[i*PW + DATA_W]) begin
        nvalid++;
        idx = i;
        pay = int'(out_routers[i*PW +: DATA_W]);
      end
    end
  endtask

  task automatic press(input bit inc, input bit dec, input bit send);
    key_inc = inc; key_dec = dec; key_send = send;
    tick(DEB_CYC + 6);
    key_inc = 1'b0; key_dec = 1'b0; key_send = 1'b0;
    tick(DEB_CYC + 6);
  endtask

  task automatic model_edit(input bit inc, input bit dec);
    if (inc == dec) return;
    if (sw_sel_data) begin
      m_data = inc ? (m_data + 1) % DMOD : (m_data + DMOD - 1) % DMOD;
    end else if (sw_sel_router) begin
      m_router = inc ? (m_router + 1) % ROUTERS : (m_router + ROUTERS - 1) % ROUTERS;
    end
  endtask

  task automatic edit(input bit inc, input bit dec);
    press(inc, dec, 1'b0);
    model_edit(inc, dec);
  endtask

  task automatic check_cont(input string tag);
    check_eq({tag, "_bus"}, int'(out_routers == exp_bus(sw_on, m_router, m_data)), 1);
    check_eq({tag, "_hdlo"}, int'(hex_data_lo), int'(glyph(m_data % 16)));
    check_eq({tag, "_hdhi"}, int'(hex_data_hi), int'(glyph((m_data / 16) % 16)));
    check_eq({tag, "_hrlo"}, int'(hex_router_lo), int'(glyph(m_router % 10)));
    check_eq({tag, "_hrhi"}, int'(hex_router_hi), int'(glyph(m_router / 10)));
  endtask

  // Count cycles in a window where exactly the expected slot fires with the expected payload.
  task automatic count_fires(input int n, input int idx, input int pay, output int fires, output int stray);
    int nv, i_o, p_o;
    fires = 0; stray = 0;
    for (int c = 0; c < n; c++) begin
      tick(1);
      scan_bus(nv, i_o, p_o);
      if (nv == 1 && i_o == idx && p_o == pay) fires++;
      else if (nv != 0) stray++;
    end
  endtask

  task automatic wait_pending(input string tag);
    int t;
    t = 0;
    while (!pending && t < 100) begin
      tick(1);
      t++;
    end
    check_eq({tag, "_pending_seen"}, int'(pending), 1);
  endtask

  initial begin
    int nv, idx, pay, fires, stray, snap;
    rst_n = 1'b0; sw_on = 1'b0; sw_oneshot = 1'b0; sw_sel_data = 1'b0; sw_sel_router = 1'b0;
    key_inc = 1'b0; key_dec = 1'b0; key_send = 1'b0; net_stall = 1'b0;
    tick(3);
    check_eq("rst_bus_zero", int'(out_routers == '0), 1);
    check_eq("rst_pending", int'(pending), 0);
    rst_n = 1'b1;
    sw_on = 1'b1;
    tick(3);
    check_cont("cont_reset");

    sw_sel_router = 1'b1;
    edit(1'b0, 1'b1);
    check_cont("router_dec_wrap");
    check_eq("router_99_hi", int'(hex_router_hi), int'(glyph(9)));
    edit(1'b1, 1'b0);
    check_cont("router_inc_wrap");

    sw_sel_router = 1'b0; sw_sel_data = 1'b1;
    for (int i = 0; i < 31; i++) edit(1'b1, 1'b0);
    sw_sel_data = 1'b0; sw_sel_router = 1'b1;
    for (int i = 0; i < 3; i++) edit(1'b1, 1'b0);
    check_cont("slot3");
    check_eq("slot3_hdlo_F", int'(hex_data_lo), int'(glyph(15)));

    // One-shot under stall: snapshot must survive an edit.
    sw_sel_router = 1'b0; sw_sel_data = 1'b1;
    sw_oneshot = 1'b1; net_stall = 1'b1;
    tick(3);
    check_eq("os_idle_bus", int'(out_routers == '0), 1);
    snap = m_data;
    press(1'b0, 1'b0, 1'b1);
    wait_pending("os");
    check_eq("os_bus_while_wait", int'(out_routers == '0), 1);
    edit(1'b1, 1'b0);
    check_eq("os_pending_hold", int'(pending), 1);
    check_eq("os_hd_edit", int'(hex_data_lo), int'(glyph(m_data % 16)));
    net_stall = 1'b0;
    count_fires(8, m_router, snap, fires, stray);
    check_eq("os_one_fire", fires, 1);
    check_eq("os_stray", stray, 0);
    check_eq("os_pending_clear", int'(pending), 0);

    sw_oneshot = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      key_inc = 1'b1; tick(1);
      key_inc = 1'b0; tick(1);
    end
    key_inc = 1'b1; tick(40);
    key_inc = 1'b0; tick(DEB_CYC + 6);
    model_edit(1'b1, 1'b0);
    check_cont("bounce");

    for (int r = 0; r < 30; r++) begin
      bit inc, dec;
      int kind;
      sw_sel_data   = 1'($urandom_range(0, 1));
      sw_sel_router = 1'($urandom_range(0, 1));
      sw_on         = ($urandom_range(0, 7) != 0);
      kind = $urandom_range(0, 2);
      inc = (kind == 0 || kind == 2);
      dec = (kind == 1 || kind == 2);
      edit(inc, dec);
      scan_bus(nv, idx, pay);
      check_eq("rnd_onehot", int'(nv <= 1), 1);
      check_cont("rnd");
    end

    // Reset aborts a pending one-shot request.
    sw_on = 1'b1; sw_sel_data = 1'b0; sw_sel_router = 1'b0;
    sw_oneshot = 1'b1; net_stall = 1'b1;
    tick(3);
    press(1'b0, 1'b0, 1'b1);
    wait_pending("rst_os");
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_data = 0; m_router = 0;
    check_eq("rst_os_pending", int'(pending), 0);
    check_eq("rst_os_bus", int'(out_routers == '0), 1);
    net_stall = 1'b0;
    count_fires(8, 0, 0, fires, stray);
    check_eq("rst_os_nofire", fires + stray, 0);
    check_eq("rst_os_hrlo", int'(hex_router_lo), int'(glyph(0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
